// File: rtl/fb_swap_if.sv
// Signal bundle between the framebuffer swap controller and its draw engine,
// framebuffer memories and display scan-out.
interface fb_swap_if #(
  parameter int unsigned NBUF  = 2,
  parameter int unsigned ADDRW = 17,
  parameter int unsigned DATAW = 4
);
  logic                  vbi;
  logic                  sync_start;
  logic                  clr_en;
  logic [DATAW-1:0]      clr_colr;
  logic                  frame_start;
  logic                  draw_done;
  logic                  draw_we;
  logic [ADDRW-1:0]      draw_addr;
  logic [DATAW-1:0]      draw_cidx;
  logic [NBUF-1:0]       mem_we;
  logic [ADDRW-1:0]      mem_waddr;
  logic [DATAW-1:0]      mem_wdata;
  logic [ADDRW-1:0]      disp_addr;
  logic [ADDRW-1:0]      mem_raddr;
  logic [NBUF*DATAW-1:0] mem_rdata;
  logic [DATAW-1:0]      disp_cidx;
  logic [1:0]            buf_disp;
  logic [1:0]            buf_draw;
  logic                  swap;
  logic                  frame_drop;

  modport slave (
    input  vbi, sync_start, clr_en, clr_colr, draw_done, draw_we, draw_addr,
           draw_cidx, disp_addr, mem_rdata,
    output frame_start, mem_we, mem_waddr, mem_wdata, mem_raddr, disp_cidx,
           buf_disp, buf_draw, swap, frame_drop
  );

  modport master (
    output vbi, sync_start, clr_en, clr_colr, draw_done, draw_we, draw_addr,
           draw_cidx, disp_addr, mem_rdata,
    input  frame_start, mem_we, mem_waddr, mem_wdata, mem_raddr, disp_cidx,
           buf_disp, buf_draw, swap, frame_drop
  );
endinterface

// File: rtl/fb_swap_ctrl.sv
// Multi-buffered framebuffer controller: tracks display/pending/draw ownership,
// clears the draw buffer, steers draw writes and swaps buffers on vertical blanking.
module fb_swap_ctrl #(
  parameter int unsigned NBUF   = 2,
  parameter int unsigned PIXELS = 76800,
  parameter int unsigned ADDRW  = 17,
  parameter int unsigned DATAW  = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  fb_swap_if.slave bus
);
  localparam int unsigned IDXW      = 2;
  localparam int unsigned LAST_ADDR = PIXELS - 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  buf_disp_q, buf_disp_d;
  logic [IDXW-1:0]  buf_draw_q, buf_draw_d;
  logic [IDXW-1:0]  pend_idx_q, pend_idx_d;
  logic             pend_vld_q, pend_vld_d;
  logic [IDXW-1:0]  disp_sel_q;
  logic [ADDRW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATAW-1:0] clr_colr_q, clr_colr_d;
  logic [DATAW-1:0] disp_cidx_q, disp_cidx_d;
  logic             frame_start_q, frame_start_d;
  logic             swap_q, swap_d;
  logic             frame_drop_q, frame_drop_d;

  logic [NBUF-1:0]  draw_sel_c;
  logic [NBUF-1:0]  mem_we_c;
  logic [ADDRW-1:0] mem_waddr_c;
  logic [DATAW-1:0] mem_wdata_c;
  logic             done_c;
  logic             free_vld_c;
  logic [IDXW-1:0]  free_idx_c;

  // State and ownership registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      buf_disp_q    <= '0;
      buf_draw_q    <= IDXW'(1);
      pend_idx_q    <= '0;
      pend_vld_q    <= 1'b0;
      disp_sel_q    <= '0;
      clr_cnt_q     <= '0;
      clr_colr_q    <= '0;
      disp_cidx_q   <= '0;
      frame_start_q <= 1'b0;
      swap_q        <= 1'b0;
      frame_drop_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_disp_q    <= buf_disp_d;
      buf_draw_q    <= buf_draw_d;
      pend_idx_q    <= pend_idx_d;
      pend_vld_q    <= pend_vld_d;
      disp_sel_q    <= buf_disp_q;
      clr_cnt_q     <= clr_cnt_d;
      clr_colr_q    <= clr_colr_d;
      disp_cidx_q   <= disp_cidx_d;
      frame_start_q <= frame_start_d;
      swap_q        <= swap_d;
      frame_drop_q  <= frame_drop_d;
    end
  end

  // Next-state, ownership update and write steering
  always_comb begin
    state_d       = state_q;
    buf_disp_d    = buf_disp_q;
    buf_draw_d    = buf_draw_q;
    pend_idx_d    = pend_idx_q;
    pend_vld_d    = pend_vld_q;
    clr_cnt_d     = clr_cnt_q;
    clr_colr_d    = clr_colr_q;
    frame_start_d = 1'b0;
    swap_d        = 1'b0;
    frame_drop_d  = 1'b0;
    draw_sel_c    = '0;
    mem_we_c      = '0;
    mem_waddr_c   = bus.draw_addr;
    mem_wdata_c   = bus.draw_cidx;
    free_vld_c    = 1'b0;
    free_idx_c    = '0;
    done_c        = (state_q == S_DRAW) && bus.draw_done;

    for (int i = 0; i < int'(NBUF); i++) begin
      draw_sel_c[i] = (buf_draw_q == IDXW'(i));
    end

    // A completed frame replaces any older pending one
    if (done_c) begin
      frame_drop_d = pend_vld_q;
      pend_vld_d   = 1'b1;
      pend_idx_d   = buf_draw_q;
      state_d      = S_IDLE;
    end

    if (bus.vbi && pend_vld_d) begin
      buf_disp_d = pend_idx_d;
      pend_vld_d = 1'b0;
      swap_d     = 1'b1;
    end

    // Lowest buffer owned by neither display nor pending, after any swap
    for (int i = int'(NBUF) - 1; i >= 0; i--) begin
      if ((IDXW'(i) != buf_disp_d) && !(pend_vld_d && (IDXW'(i) == pend_idx_d))) begin
        free_vld_c = 1'b1;
        free_idx_c = IDXW'(i);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (free_vld_c && (!bus.sync_start || bus.vbi)) begin
          buf_draw_d = free_idx_c;
          if (bus.clr_en) begin
            state_d    = S_CLEAR;
            clr_colr_d = bus.clr_colr;
            clr_cnt_d  = '0;
          end else begin
            state_d       = S_DRAW;
            frame_start_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        mem_we_c    = draw_sel_c;
        mem_waddr_c = clr_cnt_q;
        mem_wdata_c = clr_colr_q;
        if (clr_cnt_q == ADDRW'(LAST_ADDR)) begin
          clr_cnt_d     = '0;
          state_d       = S_DRAW;
          frame_start_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDRW'(1);
        end
      end
      S_DRAW: begin
        mem_we_c = bus.draw_we ? draw_sel_c : '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display read data select, using the buffer index that issued the read
  always_comb begin
    disp_cidx_d = '0;
    for (int i = 0; i < int'(NBUF); i++) begin
      if (disp_sel_q == IDXW'(i)) begin
        disp_cidx_d = bus.mem_rdata[i*DATAW +: DATAW];
      end
    end
  end

  assign bus.mem_we      = rst_n ? mem_we_c : '0;
  assign bus.mem_waddr   = mem_waddr_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.mem_raddr   = bus.disp_addr;
  assign bus.disp_cidx   = disp_cidx_q;
  assign bus.buf_disp    = buf_disp_q;
  assign bus.buf_draw    = buf_draw_q;
  assign bus.frame_start = frame_start_q;
  assign bus.swap        = swap_q;
  assign bus.frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl: a double-buffered and a triple-buffered instance
// with 16-pixel buffers.
module tb_fb_swap_ctrl;
  localparam int unsigned PIXELS = 16;
  localparam int unsigned ADDRW  = 4;
  localparam int unsigned DATAW  = 4;

  logic clk = 1'b0;
  logic rst_n2;
  logic rst_n3;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fb_swap_if #(.NBUF(2), .ADDRW(ADDRW), .DATAW(DATAW)) b2 ();
  fb_swap_if #(.NBUF(3), .ADDRW(ADDRW), .DATAW(DATAW)) b3 ();

  fb_swap_ctrl #(.NBUF(2), .PIXELS(PIXELS), .ADDRW(ADDRW), .DATAW(DATAW)) u2 (
    .clk(clk), .rst_n(rst_n2), .bus(b2)
  );
  fb_swap_ctrl #(.NBUF(3), .PIXELS(PIXELS), .ADDRW(ADDRW), .DATAW(DATAW)) u3 (
    .clk(clk), .rst_n(rst_n3), .bus(b3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n2 = 1'b0;          rst_n3 = 1'b0;
    b2.vbi = 1'b0;          b3.vbi = 1'b0;
    b2.sync_start = 1'b1;   b3.sync_start = 1'b0;
    b2.clr_en = 1'b1;       b3.clr_en = 1'b0;
    b2.clr_colr = 4'd5;     b3.clr_colr = 4'd0;
    b2.draw_done = 1'b0;    b3.draw_done = 1'b0;
    b2.draw_we = 1'b0;      b3.draw_we = 1'b0;
    b2.draw_addr = '0;      b3.draw_addr = '0;
    b2.draw_cidx = '0;      b3.draw_cidx = '0;
    b2.disp_addr = 4'd2;    b3.disp_addr = '0;
    b2.mem_rdata = 8'h93;   b3.mem_rdata = '0;

    repeat (3) cycle();
    chk("rst2_buf_disp", b2.buf_disp, 0);
    chk("rst2_buf_draw", b2.buf_draw, 1);
    chk("rst2_frame_start", b2.frame_start, 0);
    chk("rst2_swap", b2.swap, 0);
    chk("rst2_disp_cidx", b2.disp_cidx, 0);
    chk("rst2_mem_we", b2.mem_we, 0);
    chk("rst3_buf_draw", b3.buf_draw, 1);
    chk("mem_raddr_comb", b2.mem_raddr, 2);

    // Double-buffered: sync start waits for vbi
    rst_n2 = 1'b1;
    repeat (3) cycle();
    chk("wait_vbi_mem_we", b2.mem_we, 0);
    chk("wait_vbi_frame_start", b2.frame_start, 0);
    chk("disp_cidx_buf0", b2.disp_cidx, 3);
    b2.vbi = 1'b1;
    cycle();
    b2.vbi = 1'b0;
    chk("clr_buf_draw", b2.buf_draw, 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("clr_we_%0d", k), b2.mem_we, 2'b10);
      chk($sformatf("clr_addr_%0d", k), b2.mem_waddr, k);
      chk($sformatf("clr_data_%0d", k), b2.mem_wdata, 5);
      chk($sformatf("clr_fs_%0d", k), b2.frame_start, 0);
      cycle();
    end
    chk("clr_done_frame_start", b2.frame_start, 1);
    chk("draw_idle_we", b2.mem_we, 0);
    b2.draw_we = 1'b1; b2.draw_addr = 4'd3; b2.draw_cidx = 4'd7;
    #1;
    chk("draw_we", b2.mem_we, 2'b10);
    chk("draw_addr", b2.mem_waddr, 3);
    chk("draw_data", b2.mem_wdata, 7);
    cycle();
    chk("frame_start_one_cycle", b2.frame_start, 0);
    b2.draw_we = 1'b0;
    b2.draw_done = 1'b1;
    cycle();
    b2.draw_done = 1'b0;
    chk("done_no_drop", b2.frame_drop, 0);
    chk("done_no_swap", b2.swap, 0);

    // Pending frame stalls the double-buffered case even without sync start
    b2.sync_start = 1'b0;
    b2.draw_we = 1'b1;
    repeat (3) cycle();
    chk("stall_mem_we", b2.mem_we, 0);
    chk("stall_frame_start", b2.frame_start, 0);
    chk("stall_buf_disp", b2.buf_disp, 0);
    b2.draw_we = 1'b0;
    b2.vbi = 1'b1;
    cycle();
    b2.vbi = 1'b0;
    chk("swap_pulse", b2.swap, 1);
    chk("swap_buf_disp", b2.buf_disp, 1);
    chk("swap_buf_draw", b2.buf_draw, 0);
    chk("swap_clr_we", b2.mem_we, 2'b01);
    chk("swap_clr_addr", b2.mem_waddr, 0);
    chk("cidx_swap_c0", b2.disp_cidx, 3);
    cycle();
    chk("swap_one_cycle", b2.swap, 0);
    chk("cidx_swap_c1", b2.disp_cidx, 3);
    cycle();
    chk("cidx_swap_c2", b2.disp_cidx, 9);

    // Reset in the middle of a clear
    repeat (5) cycle();
    chk("mid_clr_addr", b2.mem_waddr, 7);
    chk("mid_clr_we", b2.mem_we, 2'b01);
    rst_n2 = 1'b0;
    #1;
    chk("rst_we_immediate", b2.mem_we, 0);
    cycle();
    chk("rst_mid_buf_disp", b2.buf_disp, 0);
    chk("rst_mid_buf_draw", b2.buf_draw, 1);
    chk("rst_mid_disp_cidx", b2.disp_cidx, 0);
    chk("rst_mid_we", b2.mem_we, 0);
    rst_n2 = 1'b1;
    cycle();
    chk("restart_we", b2.mem_we, 2'b10);
    chk("restart_addr", b2.mem_waddr, 0);

    // Triple-buffered, free-running, no clear
    rst_n3 = 1'b1;
    cycle();
    chk("t3_fs_first", b3.frame_start, 1);
    chk("t3_draw_first", b3.buf_draw, 1);
    b3.draw_done = 1'b1;
    cycle();
    chk("t3_done1_drop", b3.frame_drop, 0);
    chk("t3_idle_fs", b3.frame_start, 0);
    cycle();
    chk("t3_idle_done_ignored", b3.frame_drop, 0);
    chk("t3_fs_second", b3.frame_start, 1);
    chk("t3_draw_second", b3.buf_draw, 2);
    cycle();
    b3.draw_done = 1'b0;
    chk("t3_drop", b3.frame_drop, 1);
    chk("t3_drop_disp", b3.buf_disp, 0);
    cycle();
    chk("t3_no_stall_fs", b3.frame_start, 1);
    chk("t3_no_stall_draw", b3.buf_draw, 1);
    chk("t3_drop_one_cycle", b3.frame_drop, 0);
    b3.vbi = 1'b1;
    cycle();
    b3.vbi = 1'b0;
    chk("t3_swap", b3.swap, 1);
    chk("t3_swap_disp", b3.buf_disp, 2);
    b3.draw_done = 1'b1;
    cycle();
    b3.draw_done = 1'b0;
    chk("t3_pend_no_drop", b3.frame_drop, 0);
    cycle();
    chk("t3_draw_third", b3.buf_draw, 0);
    chk("t3_fs_third", b3.frame_start, 1);
    b3.draw_done = 1'b1;
    b3.vbi = 1'b1;
    cycle();
    b3.draw_done = 1'b0;
    b3.vbi = 1'b0;
    chk("coinc_disp", b3.buf_disp, 0);
    chk("coinc_drop", b3.frame_drop, 1);
    chk("coinc_swap", b3.swap, 1);
    cycle();
    chk("coinc_next_draw", b3.buf_draw, 1);
    chk("coinc_next_fs", b3.frame_start, 1);
    chk("coinc_swap_clear", b3.swap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 Parameter NBUF, default 2, number of framebuffers; legal range 2..4; index width fixed at 2 bits.
REQ-002 Parameter PIXELS, default 76800, pixels per buffer; ADDRW, default 17, address width; DATAW, default 4, colour-index width.
REQ-003 clk  in  1  pixel clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 vbi  in  1  one-cycle pulse at the start of vertical blanking.
REQ-006 sync_start  in  1  1: a new frame starts only on vbi; 0: a new frame starts as soon as a buffer is free.
REQ-007 clr_en  in  1  clear the draw buffer before drawing; clr_colr  in  DATAW  clear colour.
REQ-008 frame_start  out  1  one-cycle pulse telling the draw engine to begin a frame.
REQ-009 draw_done  in  1  one-cycle pulse from the draw engine marking a complete frame.
REQ-010 draw_we  in  1; draw_addr  in  ADDRW; draw_cidx  in  DATAW  draw-engine write port.
REQ-011 mem_we  out  NBUF  per-buffer write enable; mem_waddr  out  ADDRW; mem_wdata  out  DATAW  (shared by all buffers).
REQ-012 disp_addr  in  ADDRW  display read address; mem_raddr  out  ADDRW  (shared); mem_rdata  in  NBUF*DATAW  buffer read data, 1-cycle BRAM latency, buffer i at bits [i*DATAW +: DATAW].
REQ-013 disp_cidx  out  DATAW  colour index of the displayed buffer.
REQ-014 buf_disp  out  2; buf_draw  out  2  current buffer indices; swap  out  1; frame_drop  out  1  one-cycle status pulses.

Function
REQ-015 Buffer ownership: one display buffer (buf_disp); at most one pending buffer (complete, not yet shown); one draw buffer while CLEAR or DRAW; all other buffers are free.
REQ-016 States: IDLE, CLEAR, DRAW.
REQ-017 IDLE: the block proceeds when a free buffer exists and (sync_start==0 or vbi==1). Availability is evaluated on ownership after any same-cycle swap.
REQ-018 On leaving IDLE, buf_draw is set to the lowest index that is neither buf_disp nor pending (post-swap). The next state is CLEAR if clr_en==1, else DRAW with frame_start pulsed in the following cycle.
REQ-019 CLEAR: clr_colr is latched on entry; mem_waddr steps 0..PIXELS-1, one address per cycle, with mem_we[buf_draw]=1 and mem_wdata=latched colour. Exactly PIXELS writes occur. After the last write the block enters DRAW and frame_start pulses once.
REQ-020 DRAW: mem_we[buf_draw]=draw_we, mem_waddr=draw_addr, mem_wdata=draw_cidx, combinationally. Outside DRAW, draw_we is ignored.
REQ-021 draw_done in DRAW: buf_draw becomes pending and the state returns to IDLE. If a pending buffer already existed, it is freed and frame_drop pulses. draw_done outside DRAW is ignored.
REQ-022 vbi with a pending buffer: buf_disp <= pending index, pending is cleared, the old display buffer is freed, and swap pulses. vbi with no pending buffer: buf_disp is unchanged and there is no swap.
REQ-023 draw_done and vbi in the same cycle: the just-completed buffer is displayed at once. Any older pending buffer is freed and frame_drop pulses.
REQ-024 NBUF=2: drawing stalls in IDLE while a buffer is pending. There is no tearing because the display buffer is never written.
REQ-025 mem_we to the display buffer or the pending buffer is never asserted.
REQ-026 mem_raddr=disp_addr combinationally. disp_cidx is registered from mem_rdata[buf_disp delayed 1 cycle], giving 2 cycles total latency from disp_addr; a swap changes disp_cidx source aligned with the address stream.
REQ-027 frame_start, swap and frame_drop are registered outputs, high for exactly one cycle per event.

Reset
REQ-028 On a clk edge with rst_n==0: state=IDLE, buf_disp=0, buf_draw=1, no pending buffer, frame_start=swap=frame_drop=0, disp_cidx=0, clear counter=0.
REQ-029 mem_we is all-zero whenever rst_n==0, including mid-CLEAR or mid-DRAW. The interrupted frame is abandoned and never becomes pending.
REQ-030 The first frame after rst_n rises obeys REQ-017; no vbi is required if sync_start==0.

Verification (PIXELS=16, DATAW=4)
REQ-031 NBUF=2, clr_en=1, clr_colr=5, sync_start=1, vbi pulse -> 16 consecutive writes to buffer 1, addr 0..15, data 5; then frame_start; draw_done; next vbi -> swap, buf_disp=1.
REQ-032 NBUF=2, frame pending, sync_start=0 -> no mem_we and no frame_start until vbi; same cycle as vbi swap, the block leaves IDLE with buf_draw=0.
REQ-033 NBUF=3, sync_start=0, two draw_done before one vbi -> second draw_done pulses frame_drop. vbi displays the second-completed buffer. Drawing never stalls.
REQ-034 draw_done coincident with vbi (pending exists) -> buf_disp=just-drawn index, frame_drop=1, swap=1 in the same cycle.
REQ-035 rst_n low at clear address 7 -> mem_we=0 immediately. After release, buf_disp=0 and buf_draw=1, and a fresh clear restarts at address 0.
REQ-036 mem_rdata buffer0=3, buffer1=9, swap 0->1 -> disp_cidx changes from 3 to 9 exactly 2 cycles after the first post-swap disp_addr.
